// File: rtl/sar_seq_pkg.sv
// Shared types and sizing helpers for the SAR scan sequencer.
//   seq_state_t : scan FSM state encoding
//   ACC_GUARD   : extra accumulator bits above DATA_W (up to 8 samples summed)
//   SAMP_CNT_W  : width of the per-channel sample counter (counts 0..8)
package sar_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    CONVERT,
    EMIT,
    SCAN_END
  } seq_state_t;

  localparam int ACC_GUARD  = 3;
  localparam int SAMP_CNT_W = 4;

  function automatic int acc_width(input int data_w);
    return data_w + ACC_GUARD;
  endfunction

endpackage

// File: rtl/sar_ch_pick.sv
// Combinational channel finder: lowest set bit of mask at or above start_idx.
//   mask      : latched channel enable mask
//   start_idx : first channel to consider (may equal NUM_CH, meaning none left)
//   ch        : selected channel (0 when none found)
//   found     : a channel at or above start_idx is enabled
module sar_ch_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W:0]     start_idx,
  output logic [CH_W-1:0]   ch,
  output logic              found
);

  localparam int IW = CH_W + 1;

  // Scan from the top down so the last hit written is the lowest channel.
  always_comb begin
    ch    = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (IW'(i) >= start_idx)) begin
        ch    = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_scan_sequencer.sv
// Scan scheduler sharing one SAR conversion core across NUM_CH analog inputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_scan
// SELECT   | pick next enabled channel, drive mux_sel
// SETTLE   | mux settling down-count
// CONVERT  | sar_start on entry, wait for sar_done or watchdog
// EMIT     | present averaged result for the channel
// SCAN_END | scan_done pulse, restart if continuous
//
// Ports: clk, reset_n (async active-low); start_scan, stop_scan, continuous,
// ch_enable, settle_cycles, avg_log2 (control/config); mux_sel, sar_start,
// sar_done, sar_data (mux + SAR core handshake); result_valid, result_data,
// result_ch, busy, scan_done, timeout_err (status/results).
module sar_scan_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int SETTLE_W       = 6,
  parameter int TIMEOUT_CYCLES = 32,
  parameter bit INVERT_CODE    = 1'b1,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_scan,
  input  logic                stop_scan,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [1:0]          avg_log2,
  output logic [CH_W-1:0]     mux_sel,
  output logic                sar_start,
  input  logic                sar_done,
  input  logic [DATA_W-1:0]   sar_data,
  output logic                result_valid,
  output logic [DATA_W-1:0]   result_data,
  output logic [CH_W-1:0]     result_ch,
  output logic                busy,
  output logic                scan_done,
  output logic                timeout_err
);

  localparam int ACC_W = acc_width(DATA_W);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t            state, state_d;
  logic [NUM_CH-1:0]     en_q;
  logic [SETTLE_W-1:0]   settle_q, settle_cnt;
  logic [1:0]            avg_q;
  logic [CH_W:0]         idx;
  logic [WD_W-1:0]       wd_cnt;
  logic                  start_pend;
  logic [SAMP_CNT_W-1:0] samp_cnt;
  logic [ACC_W-1:0]      acc;

  logic [CH_W-1:0]       pick_ch;
  logic                  pick_found;
  logic [DATA_W-1:0]     code;
  logic                  abort, done_ok, wd_expire, last_samp;

  sar_ch_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .mask      (en_q),
    .start_idx (idx),
    .ch        (pick_ch),
    .found     (pick_found)
  );

  assign code  = INVERT_CODE ? ~sar_data : sar_data;
  assign abort = stop_scan && (state != IDLE);
  // sar_done in the sar_start cycle belongs to no conversion of ours.
  assign done_ok   = (state == CONVERT) && !start_pend && sar_done && !abort;
  assign wd_expire = (state == CONVERT) && !start_pend && !sar_done && !abort &&
                     (wd_cnt == WD_W'(1));
  assign last_samp = ((samp_cnt + SAMP_CNT_W'(1)) == (SAMP_CNT_W'(1) << avg_q));

  always_comb begin
    state_d      = state;
    sar_start    = 1'b0;
    result_valid = 1'b0;
    scan_done    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:     if (start_scan) state_d = SELECT;
      SELECT: begin
        if (!pick_found)            state_d = SCAN_END;
        else if (settle_q == '0)    state_d = CONVERT;
        else                        state_d = SETTLE;
      end
      SETTLE:   if (settle_cnt == SETTLE_W'(1)) state_d = CONVERT;
      CONVERT: begin
        sar_start = start_pend;
        if (done_ok)        state_d = last_samp ? EMIT : CONVERT;
        else if (wd_expire) state_d = SELECT;
      end
      EMIT: begin
        result_valid = 1'b1;
        state_d      = SELECT;
      end
      SCAN_END: begin
        scan_done = 1'b1;
        // busy stays up across the turnaround only when rescanning.
        busy      = continuous;
        state_d   = continuous ? SELECT : IDLE;
      end
      default:  state_d = IDLE;
    endcase
    if (abort) begin
      state_d      = IDLE;
      sar_start    = 1'b0;
      result_valid = 1'b0;
      scan_done    = 1'b0;
    end
  end

  assign result_data = result_valid ? DATA_W'(acc >> avg_q) : '0;
  assign result_ch   = result_valid ? mux_sel : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      en_q        <= '0;
      settle_q    <= '0;
      avg_q       <= '0;
      idx         <= '0;
      mux_sel     <= '0;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      start_pend  <= 1'b0;
      samp_cnt    <= '0;
      acc         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_d;
      // Pulse sar_start on every entry to CONVERT, including back-to-back samples.
      start_pend <= (state_d == CONVERT) && ((state != CONVERT) || done_ok);
      case (state)
        IDLE: begin
          if (start_scan) begin
            en_q        <= ch_enable;
            settle_q    <= settle_cycles;
            avg_q       <= avg_log2;
            idx         <= '0;
            timeout_err <= 1'b0;
          end
        end
        SELECT: begin
          if (pick_found) begin
            mux_sel    <= pick_ch;
            settle_cnt <= settle_q;
          end
        end
        SETTLE:   settle_cnt <= settle_cnt - SETTLE_W'(1);
        CONVERT: begin
          if (start_pend) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
          end else if (done_ok) begin
            acc      <= acc + ACC_W'(code);
            samp_cnt <= samp_cnt + SAMP_CNT_W'(1);
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            acc         <= '0;
            samp_cnt    <= '0;
            idx         <= {1'b0, mux_sel} + (CH_W+1)'(1);
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        EMIT: begin
          acc      <= '0;
          samp_cnt <= '0;
          idx      <= {1'b0, mux_sel} + (CH_W+1)'(1);
        end
        SCAN_END: begin
          if (continuous) begin
            en_q     <= ch_enable;
            settle_q <= settle_cycles;
            avg_q    <= avg_log2;
            idx      <= '0;
          end
        end
        default: ;
      endcase
      if (abort) begin
        acc      <= '0;
        samp_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
module tb_sar_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_scan, stop_scan, continuous;
  logic [3:0] ch_enable;
  logic [5:0] settle_cycles;
  logic [1:0] avg_log2;
  logic [1:0] mux_sel;
  logic       sar_start, sar_done;
  logic [7:0] sar_data;
  logic       result_valid;
  logic [7:0] result_data;
  logic [1:0] result_ch;
  logic       busy, scan_done, timeout_err;

  sar_scan_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_scan    (start_scan),
    .stop_scan     (stop_scan),
    .continuous    (continuous),
    .ch_enable     (ch_enable),
    .settle_cycles (settle_cycles),
    .avg_log2      (avg_log2),
    .mux_sel       (mux_sel),
    .sar_start     (sar_start),
    .sar_done      (sar_done),
    .sar_data      (sar_data),
    .result_valid  (result_valid),
    .result_data   (result_data),
    .result_ch     (result_ch),
    .busy          (busy),
    .scan_done     (scan_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: logs DUT events mid-cycle.
  int res_ch_q[$];
  int res_dat_q[$];
  int res_cyc_q[$];
  int start_cyc_q[$];
  int n_done = 0, done_cyc = 0, n_busy = 0, n_busy_low = 0;
  int busy_rise_cyc = 0, err_rise_cyc = 0;
  logic busy_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (result_valid) begin
      res_ch_q.push_back(int'(result_ch));
      res_dat_q.push_back(int'(result_data));
      res_cyc_q.push_back(cyc);
    end
    if (scan_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (sar_start) start_cyc_q.push_back(cyc);
    if (busy) n_busy++;
    else      n_busy_low++;
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    if (timeout_err && !err_prev) err_rise_cyc = cyc;
    busy_prev = busy;
    err_prev  = timeout_err;
  end

  // SAR core model: sar_done conv_c cycles after sar_start, code inverted on the bus.
  logic [7:0] code_tab [8];
  int conv_c = 10, code_base = 0, n_conv = 0, pend = 0;
  logic mute_en = 1'b0;
  logic [1:0] mute_ch = 2'd0;
  int done_cyc_q[$];

  initial begin
    sar_done = 1'b0;
    sar_data = 8'h00;
    forever begin
      @(negedge clk);
      sar_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          sar_data = ~code_tab[(n_conv - code_base) & 7];
          sar_done = 1'b1;
          done_cyc_q.push_back(cyc);
          n_conv++;
        end
      end
      if (sar_start && !(mute_en && mux_sel == mute_ch)) pend = conv_c;
    end
  end

  // Stimulus always sits 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start_scan = 1'b1;
    tick(1);
    start_scan = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic fill_codes(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    code_tab[0] = c0; code_tab[1] = c1; code_tab[2] = c2; code_tab[3] = c3;
    code_tab[4] = c0; code_tab[5] = c1; code_tab[6] = c2; code_tab[7] = c3;
    code_base = n_conv;
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int b_res, b_start, b_done, b_busy, b_low, b_dq, s0, k;

  task automatic mark();
    b_res   = res_dat_q.size();
    b_start = start_cyc_q.size();
    b_done  = n_done;
    b_busy  = n_busy;
    b_low   = n_busy_low;
    b_dq    = done_cyc_q.size();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got time-limit expected completion");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset_n = 1'b0; start_scan = 1'b0; stop_scan = 1'b0; continuous = 1'b0;
    ch_enable = 4'h0; settle_cycles = 6'd0; avg_log2 = 2'd0;
    fill_codes(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    #7;
    check_eq("reset_outputs",
             {busy, sar_start, result_valid, scan_done, timeout_err, mux_sel, result_ch, result_data},
             32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Two channels, settle 3, no averaging.
    ch_enable = 4'b1010; settle_cycles = 6'd3; avg_log2 = 2'd0;
    mark();
    pulse_start();
    wait_done(b_done + 1, 300, "t1_scan_end");
    check_eq("t1_start_after_select", 32'(q_at(start_cyc_q, b_start) - busy_rise_cyc), 32'd4);
    check_eq("t1_n_start", 32'(start_cyc_q.size() - b_start), 32'd2);
    check_eq("t1_n_res", 32'(res_dat_q.size() - b_res), 32'd2);
    check_eq("t1_res0_ch", 32'(q_at(res_ch_q, b_res)), 32'd1);
    check_eq("t1_res0_dat", 32'(q_at(res_dat_q, b_res)), 32'h5A);
    check_eq("t1_res1_ch", 32'(q_at(res_ch_q, b_res + 1)), 32'd3);
    check_eq("t1_res1_dat", 32'(q_at(res_dat_q, b_res + 1)), 32'h5A);
    check_eq("t1_res_latency", 32'(q_at(res_cyc_q, b_res) - q_at(done_cyc_q, b_dq)), 32'd1);
    tick(3);
    check_eq("t1_busy_low", 32'(busy), 32'd0);
    check_eq("t1_one_scan_done", 32'(n_done - b_done), 32'd1);

    // Averaging 4 samples on ch0.
    ch_enable = 4'b0001; settle_cycles = 6'd0; avg_log2 = 2'd2;
    fill_codes(8'h10, 8'h11, 8'h12, 8'h14);
    mark();
    pulse_start();
    wait_done(b_done + 1, 300, "t2_scan_end");
    check_eq("t2_n_start", 32'(start_cyc_q.size() - b_start), 32'd4);
    for (int i = 1; i < 4; i++)
      check_eq("t2_start_spacing",
               32'(q_at(start_cyc_q, b_start + i) - q_at(start_cyc_q, b_start + i - 1)), 32'd11);
    check_eq("t2_n_res", 32'(res_dat_q.size() - b_res), 32'd1);
    check_eq("t2_avg_dat", 32'(q_at(res_dat_q, b_res)), 32'h11);
    check_eq("t2_avg_ch", 32'(q_at(res_ch_q, b_res)), 32'd0);

    // Continuous scanning.
    tick(2);
    ch_enable = 4'b0001; avg_log2 = 2'd0; continuous = 1'b1;
    fill_codes(8'h21, 8'h21, 8'h21, 8'h21);
    mark();
    pulse_start();
    wait_done(b_done + 1, 300, "t3_pass1");
    mark();
    wait_done(b_done + 2, 300, "t3_pass3");
    check_eq("t3_busy_held", 32'(n_busy_low - b_low), 32'd0);
    check_eq("t3_res_per_pass", 32'(res_dat_q.size() - b_res), 32'd2);
    check_eq("t3_res_dat", 32'(q_at(res_dat_q, b_res)), 32'h21);
    continuous = 1'b0;
    mark();
    wait_done(b_done + 1, 300, "t3_last_pass");
    tick(30);
    check_eq("t3_stopped_after_pass", 32'(n_done - b_done), 32'd1);
    check_eq("t3_busy_low", 32'(busy), 32'd0);

    // Watchdog: ch2 never answers.
    ch_enable = 4'b0111; settle_cycles = 6'd0;
    mute_en = 1'b1; mute_ch = 2'd2;
    fill_codes(8'h33, 8'h44, 8'h55, 8'h66);
    mark();
    pulse_start();
    wait_done(b_done + 1, 400, "t4_scan_end");
    check_eq("t4_timeout_delay", 32'(err_rise_cyc - q_at(start_cyc_q, b_start + 2)), 32'd32);
    check_eq("t4_n_res", 32'(res_dat_q.size() - b_res), 32'd2);
    check_eq("t4_res0_ch", 32'(q_at(res_ch_q, b_res)), 32'd0);
    check_eq("t4_res0_dat", 32'(q_at(res_dat_q, b_res)), 32'h33);
    check_eq("t4_res1_ch", 32'(q_at(res_ch_q, b_res + 1)), 32'd1);
    check_eq("t4_err_sticky", 32'(timeout_err), 32'd1);
    tick(2);
    mute_en = 1'b0;
    ch_enable = 4'b0001;
    mark();
    pulse_start();
    check_eq("t4_err_cleared", 32'(timeout_err), 32'd0);
    wait_done(b_done + 1, 300, "t4_rescan_end");

    // Abort during ch1 CONVERT.
    tick(2);
    ch_enable = 4'b0011; settle_cycles = 6'd2;
    fill_codes(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    mark();
    pulse_start();
    k = 0;
    while (start_cyc_q.size() < b_start + 2 && k < 300) begin
      tick(1);
      k++;
    end
    check_eq("t5_reached_ch1", 32'(start_cyc_q.size() - b_start), 32'd2);
    tick(3);
    stop_scan = 1'b1;
    tick(1);
    stop_scan = 1'b0;
    check_eq("t5_busy_dropped", 32'(busy), 32'd0);
    tick(20);
    check_eq("t5_n_res", 32'(res_dat_q.size() - b_res), 32'd1);
    check_eq("t5_no_scan_done", 32'(n_done - b_done), 32'd0);
    check_eq("t5_no_restart", 32'(start_cyc_q.size() - b_start), 32'd2);
    check_eq("t5_idle_outputs", {busy, result_valid, sar_start}, 32'd0);
    pulse_start();
    wait_done(b_done + 1, 300, "t5_fresh_scan");
    check_eq("t5_fresh_n_res", 32'(res_dat_q.size() - b_res), 32'd3);
    check_eq("t5_fresh_ch0", 32'(q_at(res_ch_q, b_res + 1)), 32'd0);
    check_eq("t5_fresh_ch1", 32'(q_at(res_ch_q, b_res + 2)), 32'd1);
    check_eq("t5_fresh_dat", 32'(q_at(res_dat_q, b_res + 2)), 32'h3C);

    // Empty mask.
    tick(2);
    ch_enable = 4'b0000;
    mark();
    s0 = cyc;
    pulse_start();
    wait_done(b_done + 1, 50, "t6_scan_end");
    check_eq("t6_done_delay", 32'(done_cyc - s0), 32'd2);
    check_eq("t6_no_start", 32'(start_cyc_q.size() - b_start), 32'd0);
    check_eq("t6_busy_cycles", 32'(n_busy - b_busy), 32'd1);

    // Asynchronous reset mid-SETTLE.
    tick(2);
    ch_enable = 4'b0100; settle_cycles = 6'd20;
    pulse_start();
    tick(5);
    check_eq("t7_in_settle", {busy, mux_sel}, {29'd0, 1'b1, 2'd2});
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("t7_async_reset",
             {busy, sar_start, result_valid, scan_done, timeout_err, mux_sel, result_ch, result_data},
             32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
